phase_code_gen: RTL and testbench
=================================

# phase_code_gen

Parametrised, multi-code successor to the single-code phase-code block in the transmitter chain. On each rising edge of the PRT sync pulse it emits one burst of bipolar chips from a bank of up to N_CODES stored codes. It steps to the next code after every burst, which supports complementary (Golay) pulse-to-pulse alternation, and it reports busy, done and error status. Sits between sinc_generator and the DAC/modulator path.

## Interface
- NB_REG, 32, width of code words and of the count/config registers; maximum chips per code.
- NB_OUTPUT, 8, width of the signed chip output.
- N_CODES, 4, number of code words in the bank.
- i_clk  in  1  system clock; one clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_sinc  in  1  PRT sync level; only its rising edge is used.
- i_codigo  in  N_CODES*NB_REG  code bank; code k occupies bits [k*NB_REG +: NB_REG].
- i_numdig  in  NB_REG  chips per code.
- i_tb  in  NB_REG  chip duration in clocks.
- i_ncodes  in  NB_REG  number of active codes to cycle through.
- o_signal  out  NB_OUTPUT  signed chip value; 0 when idle.
- o_busy  out  1  high while chips are being emitted.
- o_done  out  1  one-cycle pulse at the end of each burst.
- o_code_idx  out  NB_REG  index of the code used by the next or current burst.
- o_err  out  1  sticky error flag; cleared only by i_rst.

## Operation
- The FSM has two states: IDLE and RUN.
- Edge detect: a register holds the previous i_sinc. A rising edge is a cycle where i_sinc=1 and the previous value was 0.
- IDLE to RUN on a rising edge, only if the effective numdig is not 0 and i_tb is not 0. On entry the block latches:
  - the selected code word,
  - the effective numdig, clamped to NB_REG when larger,
  - tb.
- Invalid config (numdig=0 or tb=0) on a rising edge: stay in IDLE, set o_err, leave o_code_idx unchanged.
- Chip order is MSB-first within numdig. Chip j (j=0..numdig-1) takes bit numdig-1-j of the latched code.
- Chip value 1 gives +(2^(NB_OUTPUT-1)-1). Chip value 0 gives -(2^(NB_OUTPUT-1)-1). Idle gives 0. For NB_OUTPUT=8 these are +127, -127 and 0.
- Each chip is held for exactly tb clocks, so a burst lasts numdig*tb clocks.
- RUN to IDLE after the last clock of the last chip. At that point o_done pulses and o_code_idx advances.
- Code index rule:
  - Effective ncodes: an i_ncodes of 0 is treated as 1; values above N_CODES are clamped to N_CODES.
  - The index advances as idx = (idx+1 >= ncodes_eff) ? 0 : idx+1.
  - If i_ncodes changes so that idx >= ncodes_eff, the next burst uses index 0.
- A rising edge of i_sinc while in RUN (overlap) is ignored: the burst continues unchanged and o_err is set.
- Configuration inputs are sampled only at burst start. Changes during RUN take effect at the next burst.

## Timing
- Reset values: o_signal=0, o_busy=0, o_done=0, o_code_idx=0, o_err=0, state IDLE, edge register 0.
- Reset mid-burst: on the next clock all outputs return to their reset values. A sinc level already high at reset release does not count as an edge.
- Latency: when the edge is detected at clock edge n, the first chip appears on o_signal after edge n+1. o_busy rises in that same cycle.
- o_signal, o_busy, o_done and o_code_idx are all registered.
- o_done is high for exactly one cycle, in the cycle where o_signal returns to 0 and o_busy falls.
- o_code_idx updates in the same cycle as o_done.
- A new edge in the same cycle as o_done is accepted. The new burst uses the updated index and its first chip follows one cycle later, so there is one idle cycle at 0.
- Chip counter and tb counter are NB_REG wide with no wrap; the maximum valid tb is 2^NB_REG-1.

## Structure
- Shared package phase_code_pkg holds:
  - state encoding (ST_IDLE, ST_RUN);
  - the amplitude constants, computed from NB_OUTPUT;
  - the ncodes clamp function.
- Sub-module chip_timer:
  - loads tb and emits a one-cycle chip_tick on the final clock of each chip;
  - is reloaded by a start strobe;
  - is cleared by i_rst.
- The top level holds the FSM, the code latch and shifter, the chip counter, the code-index register and the output register.

## Test plan
- Barker-11, i_codigo[0]=32'b11100010010, numdig=11, tb=4, ncodes=1 → 44 cycles of chips +127,+127,+127,-127,-127,-127,+127,-127,-127,+127,-127 at 4 clocks each; one o_done pulse; o_code_idx stays 0.
- Golay pair: code0=4'b1110, code1=4'b1101, numdig=4, tb=2, ncodes=2, three sync edges → bursts use codes 0,1,0; o_code_idx goes 1,0,1 after each o_done.
- Overlap: second sinc edge 10 cycles into a 44-cycle burst → burst completes unchanged, o_err=1, no second burst.
- Invalid config: numdig=0 or tb=0 with a sync edge → o_signal stays 0, o_busy stays 0, o_err=1, o_code_idx unchanged.
- Reset mid-burst at cycle 20 → o_signal=0, o_busy=0, o_code_idx=0, o_err=0 next cycle; next edge starts from code 0.
- Clamping: numdig=40 with NB_REG=32 gives 32 chips; ncodes=7 with N_CODES=4 cycles indices 0..3.

Source files
------------

// File: rtl/phase_code_pkg.sv
// Shared definitions for the phase-code generator: FSM encoding,
// chip amplitudes derived from the output width, and the ncodes clamp.
package phase_code_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Positive chip amplitude, +(2^(nb_output-1)-1).
  function automatic int amp_pos(input int nb_output);
    return (32'sd1 << (nb_output - 32'sd1)) - 32'sd1;
  endfunction

  // Negative chip amplitude, symmetric with amp_pos.
  function automatic int amp_neg(input int nb_output);
    return 32'sd0 - amp_pos(nb_output);
  endfunction

  // Effective number of codes: 0 behaves as 1, anything above the bank size saturates.
  function automatic logic [31:0] clamp_ncodes(input logic [31:0] ncodes,
                                               input logic [31:0] max_codes);
    if (ncodes == 32'd0) begin
      return 32'd1;
    end else if (ncodes > max_codes) begin
      return max_codes;
    end else begin
      return ncodes;
    end
  endfunction

endpackage

// File: rtl/phase_code_gen_if.sv
// Sync/config/status bundle between the PRT timing logic and the phase-code generator.
interface phase_code_gen_if #(
  parameter int NB_REG    = 32,
  parameter int NB_OUTPUT = 8,
  parameter int N_CODES   = 4
);
  logic                        i_sinc;
  logic [N_CODES*NB_REG-1:0]   i_codigo;
  logic [NB_REG-1:0]           i_numdig;
  logic [NB_REG-1:0]           i_tb;
  logic [NB_REG-1:0]           i_ncodes;
  logic signed [NB_OUTPUT-1:0] o_signal;
  logic                        o_busy;
  logic                        o_done;
  logic [NB_REG-1:0]           o_code_idx;
  logic                        o_err;

  modport master (
    output i_sinc, i_codigo, i_numdig, i_tb, i_ncodes,
    input  o_signal, o_busy, o_done, o_code_idx, o_err
  );

  modport slave (
    input  i_sinc, i_codigo, i_numdig, i_tb, i_ncodes,
    output o_signal, o_busy, o_done, o_code_idx, o_err
  );
endinterface

// File: rtl/chip_timer.sv
// Chip-duration timer: reloaded with tb on a start strobe, raises tick_o on
// the last clock of every chip while the burst is running.
module chip_timer #(
  parameter int NB_REG = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [NB_REG-1:0] tb_i,
  output logic              tick_o
);

  logic [NB_REG-1:0] cnt_q;
  logic [NB_REG-1:0] tb_q;

  assign tick_o = run_i && (cnt_q == '0);

  // Down-counter: counts tb-1..0 for each chip, reloading after the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      tb_q  <= '0;
    end else if (start_i) begin
      tb_q  <= tb_i;
      cnt_q <= tb_i - NB_REG'(1);
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_q <= tb_q - NB_REG'(1);
      end else begin
        cnt_q <= cnt_q - NB_REG'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/phase_code_gen.sv
// Multi-code bipolar phase-code generator: one burst per PRT sync rising edge,
// stepping through the code bank after each burst (Golay alternation).
module phase_code_gen
  import phase_code_pkg::*;
#(
  parameter int NB_REG    = 32,
  parameter int NB_OUTPUT = 8,
  parameter int N_CODES   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  phase_code_gen_if.slave bus
);

  localparam logic signed [NB_OUTPUT-1:0] AMP_P = NB_OUTPUT'(amp_pos(NB_OUTPUT));
  localparam logic signed [NB_OUTPUT-1:0] AMP_N = NB_OUTPUT'(amp_neg(NB_OUTPUT));

  logic [0:0]        state_q, state_d;
  logic              sinc_prev_q, armed_q;
  logic [NB_REG-1:0] code_q, code_d;
  logic [NB_REG-1:0] chips_q, chips_d;
  logic [NB_REG-1:0] idx_q, idx_d;
  logic [NB_REG-1:0] ncodes_q, ncodes_d;
  logic              end_q;

  logic signed [NB_OUTPUT-1:0] o_signal_q;
  logic                        o_busy_q, o_done_q, o_err_q;
  logic [NB_REG-1:0]           o_code_idx_q;

  logic              rise_s, cfg_ok_s, start_s, end_s, err_set_s, tick_s, run_s;
  logic [NB_REG-1:0] numdig_eff_s, ncodes_eff_s, sel_s, code_sel_s;

  // armed_q masks the first clock after reset so a sinc already high is not an edge.
  assign rise_s       = armed_q && bus.i_sinc && !sinc_prev_q;
  assign numdig_eff_s = (bus.i_numdig > NB_REG'(NB_REG)) ? NB_REG'(NB_REG) : bus.i_numdig;
  assign ncodes_eff_s = NB_REG'(clamp_ncodes(32'(bus.i_ncodes), 32'(N_CODES)));
  assign cfg_ok_s     = (numdig_eff_s != '0) && (bus.i_tb != '0);
  assign sel_s        = (idx_q >= ncodes_eff_s) ? '0 : idx_q;
  assign run_s        = (state_q == ST_RUN);
  assign start_s      = (state_q == ST_IDLE) && rise_s && cfg_ok_s;
  assign end_s        = run_s && tick_s && (chips_q == NB_REG'(1));
  assign err_set_s    = rise_s && (run_s || !cfg_ok_s);

  chip_timer #(.NB_REG(NB_REG)) u_chip_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .start_i (start_s),
    .run_i   (run_s),
    .tb_i    (bus.i_tb),
    .tick_o  (tick_s)
  );

  // Code bank mux for the burst about to start.
  always_comb begin
    code_sel_s = '0;
    for (int k = 0; k < N_CODES; k++) begin
      if (sel_s == NB_REG'(k)) begin
        code_sel_s = bus.i_codigo[k*NB_REG +: NB_REG];
      end else begin
        code_sel_s = code_sel_s;
      end
    end
  end

  // FSM next state: latch config at burst start, shift the code MSB-first per chip.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    chips_d  = chips_q;
    idx_d    = idx_q;
    ncodes_d = ncodes_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d  = ST_RUN;
          code_d   = code_sel_s << (NB_REG'(NB_REG) - numdig_eff_s);
          chips_d  = numdig_eff_s;
          idx_d    = sel_s;
          ncodes_d = ncodes_eff_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (end_s) begin
          state_d = ST_IDLE;
          idx_d   = ((idx_q + NB_REG'(1)) >= ncodes_q) ? '0 : (idx_q + NB_REG'(1));
        end else if (tick_s) begin
          chips_d = chips_q - NB_REG'(1);
          code_d  = code_q << 1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, code latch, counters and edge-detect registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sinc_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      code_q      <= '0;
      chips_q     <= '0;
      idx_q       <= '0;
      ncodes_q    <= NB_REG'(1);
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sinc_prev_q <= bus.i_sinc;
      armed_q     <= 1'b1;
      code_q      <= code_d;
      chips_q     <= chips_d;
      idx_q       <= idx_d;
      ncodes_q    <= ncodes_d;
      end_q       <= end_s;
    end
  end

  // Output register: one cycle behind the FSM so done/idx land as busy falls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_signal_q   <= '0;
      o_busy_q     <= 1'b0;
      o_done_q     <= 1'b0;
      o_code_idx_q <= '0;
      o_err_q      <= 1'b0;
    end else begin
      o_signal_q   <= run_s ? (code_q[NB_REG-1] ? AMP_P : AMP_N) : '0;
      o_busy_q     <= run_s;
      o_done_q     <= end_q;
      o_code_idx_q <= idx_q;
      o_err_q      <= o_err_q || err_set_s;
    end
  end

  assign bus.o_signal   = o_signal_q;
  assign bus.o_busy     = o_busy_q;
  assign bus.o_done     = o_done_q;
  assign bus.o_code_idx = o_code_idx_q;
  assign bus.o_err      = o_err_q;

endmodule

// File: tb/tb_phase_code_gen.sv
// Scoreboard bench for phase_code_gen: stimulus pushes expected chips and
// post-burst code indices; a negedge monitor pops and compares.
module tb_phase_code_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   model_idx = 0;

  logic signed [7:0] exp_chips[$];
  logic [31:0]       exp_idx[$];

  phase_code_gen_if #(.NB_REG(32), .NB_OUTPUT(8), .N_CODES(4)) bus ();

  phase_code_gen #(.NB_REG(32), .NB_OUTPUT(8), .N_CODES(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every busy cycle against the chip queue, idle cycles against 0.
  always @(negedge clk) begin
    if (rst) begin
      exp_chips.delete();
      exp_idx.delete();
    end else begin
      if (bus.o_busy) begin
        if (exp_chips.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_chip actual=%0d expected=none t=%0t", bus.o_signal, $time);
        end else begin
          chk("chip", 32'(bus.o_signal), 32'(exp_chips.pop_front()));
        end
      end else begin
        chk("idle_zero", 32'(bus.o_signal), 32'd0);
      end
      if (bus.o_done) begin
        chk("done_busy_low", 32'(bus.o_busy), 32'd0);
        if (exp_idx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
        end else begin
          chk("code_idx", bus.o_code_idx, exp_idx.pop_front());
        end
      end
    end
  end

  task automatic expect_burst();
    logic [31:0] nd, nc, sel, code;
    int s;
    nd = (bus.i_numdig > 32'd32) ? 32'd32 : bus.i_numdig;
    nc = (bus.i_ncodes == 32'd0) ? 32'd1 : ((bus.i_ncodes > 32'd4) ? 32'd4 : bus.i_ncodes);
    sel = (32'(model_idx) >= nc) ? 32'd0 : 32'(model_idx);
    s = int'(sel);
    code = bus.i_codigo[s*32 +: 32];
    for (int j = 0; j < int'(nd); j++) begin
      for (int t = 0; t < int'(bus.i_tb); t++) begin
        exp_chips.push_back(code[int'(nd) - 1 - j] ? 8'sd127 : -8'sd127);
      end
    end
    model_idx = ((sel + 32'd1) >= nc) ? 0 : int'(sel) + 1;
    exp_idx.push_back(32'(model_idx));
  endtask

  task automatic trigger();
    bus.i_sinc = 1'b1;
    @(negedge clk);
    bus.i_sinc = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_done && n < 2000);
    if (!bus.o_done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  task automatic run_burst(input string name);
    expect_burst();
    trigger();
    wait_done(name);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(negedge clk);
    chk({name, "_signal"}, 32'(bus.o_signal), 32'd0);
    chk({name, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({name, "_done"}, 32'(bus.o_done), 32'd0);
    chk({name, "_idx"}, bus.o_code_idx, 32'd0);
    chk({name, "_err"}, 32'(bus.o_err), 32'd0);
    rst = 1'b0;
    model_idx = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.i_sinc   = 1'b0;
    bus.i_codigo = '0;
    bus.i_numdig = 32'd11;
    bus.i_tb     = 32'd4;
    bus.i_ncodes = 32'd1;
    repeat (3) @(negedge clk);
    do_reset("reset");

    // Barker-11 with explicit first-chip latency check.
    bus.i_codigo[31:0] = 32'h0000_0712;
    expect_burst();
    bus.i_sinc = 1'b1;
    @(negedge clk);
    chk("latency_busy_low", 32'(bus.o_busy), 32'd0);
    bus.i_sinc = 1'b0;
    @(negedge clk);
    chk("latency_busy_high", 32'(bus.o_busy), 32'd1);
    chk("latency_first_chip", 32'(bus.o_signal), 32'(8'sd127));
    wait_done("barker");
    @(negedge clk);
    chk("barker_err", 32'(bus.o_err), 32'd0);

    // Golay pair: codes 0,1,0; indices 1,0,1.
    bus.i_codigo[31:0]  = 32'h0000_000E;
    bus.i_codigo[63:32] = 32'h0000_000D;
    bus.i_numdig = 32'd4;
    bus.i_tb     = 32'd2;
    bus.i_ncodes = 32'd2;
    run_burst("golay0");
    run_burst("golay1");
    run_burst("golay2");
    chk("golay_idx_final", bus.o_code_idx, 32'd1);

    // Overlap: second edge mid-burst is ignored and flags an error.
    bus.i_codigo[31:0] = 32'h0000_0712;
    bus.i_numdig = 32'd11;
    bus.i_tb     = 32'd4;
    bus.i_ncodes = 32'd1;
    expect_burst();
    trigger();
    repeat (8) @(negedge clk);
    trigger();
    wait_done("overlap");
    @(negedge clk);
    chk("overlap_err", 32'(bus.o_err), 32'd1);
    repeat (60) @(negedge clk);
    chk("overlap_no_second", 32'(bus.o_busy), 32'd0);

    // Invalid config: numdig=0 after index moved to 1.
    do_reset("reset2");
    bus.i_codigo[31:0] = 32'h0000_000E;
    bus.i_numdig = 32'd4;
    bus.i_tb     = 32'd2;
    bus.i_ncodes = 32'd2;
    run_burst("pre_invalid");
    bus.i_numdig = 32'd0;
    trigger();
    repeat (10) @(negedge clk);
    chk("inv_numdig_busy", 32'(bus.o_busy), 32'd0);
    chk("inv_numdig_err", 32'(bus.o_err), 32'd1);
    chk("inv_numdig_idx", bus.o_code_idx, 32'd1);
    do_reset("reset3");
    bus.i_numdig = 32'd4;
    bus.i_tb     = 32'd0;
    trigger();
    repeat (10) @(negedge clk);
    chk("inv_tb_busy", 32'(bus.o_busy), 32'd0);
    chk("inv_tb_err", 32'(bus.o_err), 32'd1);

    // Reset mid-burst, then the next burst restarts from code 0.
    do_reset("reset4");
    bus.i_tb = 32'd2;
    run_burst("pre_midreset");
    bus.i_tb = 32'd8;
    expect_burst();
    trigger();
    repeat (19) @(negedge clk);
    do_reset("midreset");
    bus.i_tb = 32'd2;
    run_burst("after_midreset");
    chk("after_midreset_idx", bus.o_code_idx, 32'd1);

    // Clamping: numdig 40 -> 32 chips; ncodes 7 -> indices 0..3.
    do_reset("reset5");
    bus.i_codigo = {32'h0000_0009, 32'h0000_0005, 32'h0000_0003, 32'hA50F_3C96};
    bus.i_numdig = 32'd40;
    bus.i_tb     = 32'd1;
    bus.i_ncodes = 32'd7;
    run_burst("clamp_numdig");
    bus.i_numdig = 32'd4;
    run_burst("clamp_idx1");
    run_burst("clamp_idx2");
    run_burst("clamp_idx3");
    chk("clamp_wrap_idx", bus.o_code_idx, 32'd0);

    // Back-to-back: edge in the o_done cycle is accepted after one idle cycle.
    expect_burst();
    trigger();
    wait_done("b2b_first");
    bus.i_sinc = 1'b1;
    expect_burst();
    @(negedge clk);
    chk("b2b_gap_busy", 32'(bus.o_busy), 32'd0);
    bus.i_sinc = 1'b0;
    @(negedge clk);
    chk("b2b_start_busy", 32'(bus.o_busy), 32'd1);
    wait_done("b2b_second");
    @(negedge clk);
    chk("b2b_err", 32'(bus.o_err), 32'd0);

    repeat (5) @(negedge clk);
    chk("chips_drained", 32'(exp_chips.size()), 32'd0);
    chk("idx_drained", 32'(exp_idx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
